uart_tx_buffered: RTL and testbench

Buffered 8N1 UART transmitter on the downstream side of the message printer: accepts bytes on a `data`/`new_data`/`busy` handshake and serialises them onto the `tx` pin. An internal FIFO lets the printer burst a whole decimal result string without waiting per byte. It sits between the printer and the board's serial TX pin, and pairs with the existing UART receiver on the rx side.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 56 +++++
 rtl/uart_tx_buffered.sv | 118 +++++++++++
 tb/tb_uart_tx_buffered.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding and the byte width
// common to the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; head is presented
// combinationally on rd_data, full/empty come from the occupancy count.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  // A write while full is dropped even if a pop frees a slot in the same cycle.
  assign w_push = wr_en && !full;
  assign w_pop  = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serializer FSM that
// drives a registered tx line.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 100,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            data,
  input  logic                         new_data,
  input  logic                         block,
  output logic                         busy,
  output logic                         tx,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam int unsigned CW = $clog2(CLK_PER_BIT);

  tx_state_e         r_state, w_state_d;
  logic [CW-1:0]     r_baud, w_baud_d;
  logic [2:0]        r_bit, w_bit_d;
  logic [DATA_W-1:0] r_shift, w_shift_d;
  logic              r_tx, w_tx_d;
  logic              r_overflow;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_baud_last;
  logic [DATA_W-1:0] w_rd_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (new_data),
    .wr_data (data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .count   (fifo_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_baud_last = (r_baud == CW'(CLK_PER_BIT - 1));

  always_comb begin
    w_state_d = r_state;
    w_baud_d  = r_baud + CW'(1);
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    w_pop     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_baud_d = '0;
        if (!w_empty && !block) begin
          w_pop     = 1'b1;
          w_shift_d = w_rd_data;
          w_bit_d   = '0;
          w_state_d = START;
        end
      end
      START: begin
        if (w_baud_last) begin
          w_baud_d  = '0;
          w_state_d = DATA;
        end
      end
      DATA: begin
        if (w_baud_last) begin
          w_baud_d = '0;
          if (r_bit == 3'd7) w_state_d = STOP;
          else               w_bit_d   = r_bit + 3'd1;
        end
      end
      STOP: begin
        if (w_baud_last) begin
          w_baud_d  = '0;
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase

    // tx is registered from the next state so the line changes with the state.
    unique case (w_state_d)
      START:   w_tx_d = 1'b0;
      DATA:    w_tx_d = w_shift_d[w_bit_d];
      default: w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_baud     <= w_baud_d;
      r_bit      <= w_bit_d;
      r_shift    <= w_shift_d;
      r_tx       <= w_tx_d;
      r_overflow <= new_data && w_full;
    end
  end

  assign tx       = r_tx;
  assign busy     = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: stimulus queues expected bytes, a
// serial-line monitor decodes frames and compares them against the queue.
module tb_uart_tx_buffered;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNTW  = $clog2(DEPTH) + 1;
  localparam int          PITCH = 10 * CPB + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      data;
  logic            new_data;
  logic            block;
  logic            busy;
  logic            tx;
  logic [CNTW-1:0] fifo_count;
  logic            overflow;

  uart_tx_buffered #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .new_data   (new_data),
    .block      (block),
    .busy       (busy),
    .tx         (tx),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         errors  = 0;
  int         checks  = 0;
  int         nframes = 0;
  logic [7:0] exp_q[$];
  int         starts[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Serial receiver model: samples mid-bit, aborts any frame on reset.
  initial begin : monitor
    bit         active;
    int         s;
    int         off;
    logic [7:0] b;
    active = 1'b0;
    s      = 0;
    b      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          s      = cyc;
          b      = '0;
          starts.push_back(cyc);
        end
      end else begin
        off = cyc - s;
        if (off == CPB / 2) chk("start_bit", {31'd0, tx}, 32'd0);
        if (off >= CPB && off < 9 * CPB && ((off - CPB) % CPB) == CPB / 2)
          b[(off - CPB) / CPB] = tx;
        if (off == 9 * CPB + CPB / 2) begin
          chk("stop_bit", {31'd0, tx}, 32'd1);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: got 0x%0h with no byte queued at cycle %0d", b, cyc);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (b !== e) begin
              errors++;
              $display("FAIL rx_byte: got 0x%0h expected 0x%0h at cycle %0d", b, e, cyc);
            end
          end
          nframes++;
        end
        if (off == 10 * CPB - 1) active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic goto_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    data     = b;
    new_data = 1'b1;
    @(posedge clk);
    #1;
    new_data = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int k = 0;
    while (nframes < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(name, nframes, n);
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int k = 0;
    while (starts.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(name, starts.size(), n);
  endtask

  initial begin : stimulus
    int         w;
    int         base;
    int         nf;
    int         s1;
    int         c;
    bit         ok;
    logic [7:0] b;

    rst      = 1'b1;
    new_data = 1'b0;
    block    = 1'b0;
    data     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_count", fifo_count, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1;

    // Single byte: start bit at w+2, bit 7 (0) ends at w+37, stop from w+38.
    w = cyc;
    exp_q.push_back(8'h41);
    write_byte(8'h41);
    @(negedge clk);
    chk("single_count_1", fifo_count, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("single_count_0", fifo_count, 32'd0);
    chk("single_tx_start", {31'd0, tx}, 32'd0);
    goto_cycle(w + 37);
    @(negedge clk);
    chk("single_tx_bit7", {31'd0, tx}, 32'd0);
    goto_cycle(w + 38);
    @(negedge clk);
    chk("single_tx_stop", {31'd0, tx}, 32'd1);
    wait_frames(1, 100, "single_done");
    chk("single_latency", starts[0], w + 2);
    repeat (5) @(posedge clk);
    #1;

    // Burst of 16 on consecutive cycles: the first pop keeps the FIFO off full.
    base = starts.size();
    w    = cyc;
    for (int i = 0; i < 16; i++) begin
      b        = (i < 10) ? 8'(8'h30 + i) : 8'(8'h41 + i - 10);
      exp_q.push_back(b);
      data     = b;
      new_data = 1'b1;
      @(negedge clk);
      chk("burst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
    end
    new_data = 1'b0;
    @(negedge clk);
    chk("burst_count", fifo_count, 32'd15);
    wait_frames(base + 16, 16 * PITCH + 100, "burst_done");
    chk("burst_first_start", starts[base], w + 2);
    for (int i = 1; i < 16; i++) chk("burst_pitch", starts[base + i] - starts[base + i - 1], PITCH);

    // Overflow while blocked: 16 fill the FIFO, the 17th is dropped.
    block = 1'b1;
    base  = starts.size();
    nf    = nframes;
    for (int i = 0; i < 16; i++) begin
      b        = 8'(8'h60 + i);
      exp_q.push_back(b);
      data     = b;
      new_data = 1'b1;
      @(posedge clk);
      #1;
    end
    new_data = 1'b0;
    @(negedge clk);
    chk("ovf_count_full", fifo_count, 32'd16);
    chk("ovf_busy", {31'd0, busy}, 32'd1);
    chk("ovf_no_pulse_yet", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    write_byte(8'hEE);
    @(negedge clk);
    chk("ovf_pulse", {31'd0, overflow}, 32'd1);
    chk("ovf_count_held", fifo_count, 32'd16);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ovf_pulse_one_cycle", {31'd0, overflow}, 32'd0);
    chk("ovf_no_start_blocked", starts.size(), base);
    @(posedge clk);
    #1;
    block = 1'b0;
    wait_frames(nf + 16, 16 * PITCH + 100, "ovf_drain");
    repeat (3 * PITCH) @(posedge clk);
    #1;
    chk("ovf_17th_dropped", starts.size(), base + 16);
    chk("ovf_queue_empty", exp_q.size(), 0);

    // Block raised mid-frame: frame 1 completes, frame 2 waits for release.
    base = starts.size();
    nf   = nframes;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    write_byte(8'hA5);
    write_byte(8'h3C);
    wait_starts(base + 1, 50, "blk_first_start");
    s1 = starts[base];
    goto_cycle(s1 + 3 * CPB);
    block = 1'b1;
    goto_cycle(s1 + 10 * CPB);
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("blk_tx_idle", {31'd0, ok}, 32'd1);
    chk("blk_frame1_done", nframes, nf + 1);
    chk("blk_no_second_start", starts.size(), base + 1);
    // c is the first cycle with block low; IDLE pops then, start bit follows.
    c     = cyc;
    block = 1'b0;
    wait_starts(base + 2, 50, "blk_second_start");
    chk("blk_release_latency", starts[base + 1], c + 1);
    wait_frames(nf + 2, 2 * PITCH, "blk_done");

    // Reset in the middle of a frame with more bytes queued.
    base = starts.size();
    nf   = nframes;
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    wait_starts(base + 1, 50, "rst_first_start");
    s1 = starts[base];
    goto_cycle(s1 + 14);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_count", fifo_count, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    ok = 1'b1;
    for (int k = 0; k < 3 * PITCH; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
    end
    chk("rst_tx_stays_idle", {31'd0, ok}, 32'd1);
    chk("rst_no_more_starts", starts.size(), base + 1);
    chk("rst_no_frames_done", nframes, nf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
